// File: rtl/fetch_decode_stage.sv
// Instruction fetch over a req/valid handshake plus the IF/ID register with field decode.
// Optional perf counters (fetch_count, stall_cycles) are built when FETCH_PERF_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | issue imem_req for pc
// WAIT     | request outstanding, waiting for imem_valid
// HOLD     | word captured into the buffer while stalled; waits for stall=0
// DRAIN    | redirected while a request was outstanding; drop that beat
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [6:0]  opcode,
  output logic [2:0]  f3,
  output logic [6:0]  f7,
  output logic [31:0] immediate
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_word, buf_pc;
  logic        load_buf;
  logic        deliver;
  logic [31:0] dsrc_word, dsrc_pc;

  function automatic logic [31:0] imm_of(input logic [31:0] inst);
    logic [31:0] imm;
    imm = 32'h0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'h000};
      default:
        imm = 32'h0;
    endcase
    return imm;
  endfunction

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_buf  = 1'b0;
    deliver   = 1'b0;
    dsrc_word = imem_rdata;
    dsrc_pc   = pc;
    if (redirect) begin
      // An outstanding request must be drained so its late beat is not taken as the target.
      state_nxt = (state == ST_WAIT && !imem_valid) ? ST_DRAIN : ST_FETCH;
      pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      case (state)
        ST_FETCH: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (imem_valid) begin
            pc_nxt = pc + 32'd4;
            if (stall) begin
              load_buf  = 1'b1;
              state_nxt = ST_HOLD;
            end else begin
              deliver   = 1'b1;
              state_nxt = ST_FETCH;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            deliver   = 1'b1;
            dsrc_word = buf_word;
            dsrc_pc   = buf_pc;
            state_nxt = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_valid) state_nxt = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      buf_word <= 32'h0;
      buf_pc   <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (redirect) begin
        buf_word <= 32'h0;
        buf_pc   <= 32'h0;
      end else if (load_buf) begin
        buf_word <= imem_rdata;
        buf_pc   <= pc;
      end
    end
  end

  // Redirect forces a bubble even under stall; otherwise stall freezes whatever is shown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
      rs1         <= 5'h0;
      rs2         <= 5'h0;
      rd          <= 5'h0;
      opcode      <= 7'h0;
      f3          <= 3'h0;
      f7          <= 7'h0;
      immediate   <= 32'h0;
    end else if (redirect || (!deliver && !stall)) begin
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
      rs1         <= 5'h0;
      rs2         <= 5'h0;
      rd          <= 5'h0;
      opcode      <= 7'h0;
      f3          <= 3'h0;
      f7          <= 7'h0;
      immediate   <= 32'h0;
    end else if (deliver) begin
      pc_out      <= dsrc_pc;
      instr_valid <= 1'b1;
      rs1         <= dsrc_word[19:15];
      rs2         <= dsrc_word[24:20];
      rd          <= dsrc_word[11:7];
      opcode      <= dsrc_word[6:0];
      f3          <= dsrc_word[14:12];
      f7          <= dsrc_word[31:25];
      immediate   <= imm_of(dsrc_word);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count  <= 32'h0;
      stall_cycles <= 32'h0;
    end else begin
      if (deliver) fetch_count <= fetch_count + 32'd1;
      if (stall && state == ST_HOLD) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed table-driven bench for fetch_decode_stage: one table row per clock cycle,
// plus hand-written sequences for reset state, async reset mid-request and perf counters.
module tb_fetch_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] immediate;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instr_valid(instr_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode),
    .f3(f3), .f7(f7), .immediate(immediate)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ivld;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [6:0]  e_op;
    logic [4:0]  e_rd;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [31:0] e_imm;
    logic [31:0] e_pc;
  } rec_t;

  localparam int NV = 23;
  rec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input rec_t r);
    chk({tag, ".req"},   {31'h0, imem_req},    {31'h0, r.e_req});
    chk({tag, ".addr"},  imem_addr,            r.e_addr);
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, r.e_iv});
    chk({tag, ".op"},    {25'h0, opcode},      {25'h0, r.e_op});
    chk({tag, ".rd"},    {27'h0, rd},          {27'h0, r.e_rd});
    chk({tag, ".rs1"},   {27'h0, rs1},         {27'h0, r.e_rs1});
    chk({tag, ".rs2"},   {27'h0, rs2},         {27'h0, r.e_rs2});
    chk({tag, ".f3"},    {29'h0, f3},          {29'h0, r.e_f3});
    chk({tag, ".f7"},    {25'h0, f7},          {25'h0, r.e_f7});
    chk({tag, ".imm"},   immediate,            r.e_imm);
    chk({tag, ".pc"},    pc_out,               r.e_pc);
  endtask

  initial begin
    rec_t idle0;
    //          stall redir rpc            ivld rdata          req addr           iv op     rd     rs1   rs2    f3    f7     imm            pc
    vec[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b1, 32'h4,        1'b1, 7'h13, 5'd1,  5'd0, 5'd5,  3'd0, 7'h00, 32'h5,        32'h0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFE000EE3, 1'b1, 32'h8,        1'b1, 7'h63, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 32'h4};
    vec[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h12345137, 1'b0, 32'hC,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hC,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 7'h37, 5'd2,  5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, 32'h8};
    vec[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hC,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[9]  = '{1'b0, 1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b1, 32'h100,      1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00112623, 1'b1, 32'h104,      1'b1, 7'h23, 5'd12, 5'd2, 5'd1,  3'd2, 7'h00, 32'hC,        32'h100};
    vec[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h104,      1'b1, 7'h23, 5'd12, 5'd2, 5'd1,  3'd2, 7'h00, 32'hC,        32'h100};
    vec[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h104,      1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[15] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFC, 1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hFFFFFFFC, 1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h008000EF, 1'b1, 32'h0,        1'b1, 7'h6F, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00, 32'h8,        32'hFFFFFFFC};
    vec[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h002081B3, 1'b1, 32'h4,        1'b1, 7'h33, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[20] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        1'b0, 7'h00, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0,        32'h0};
    vec[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFF00093, 1'b1, 32'h8,        1'b1, 7'h13, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'h4};
    vec[22] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 7'h13, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'h4};

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    // Reset state: FETCH at RESET_PC, decode outputs cleared.
    idle0 = vec[0];
    idle0.e_req = 1'b1;
    chk_outs("reset", idle0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      stall       = vec[i].stall;
      redirect    = vec[i].redir;
      redirect_pc = vec[i].rpc;
      imem_valid  = vec[i].ivld;
      imem_rdata  = vec[i].rdata;
      @(posedge clock);
      #1;
      chk_outs($sformatf("row%0d", i), vec[i]);
    end

`ifdef FETCH_PERF_EN
    chk("perf.fetch_count", fetch_count, 32'd7);
    chk("perf.stall_cycles", stall_cycles, 32'd1);
`endif

    // Async reset while WAIT holds a stalled, valid instruction on the outputs.
    @(negedge clock);
    stall = 1'b0; redirect = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid.valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mid.op", {25'h0, opcode}, 32'h0);
    chk("rst_mid.imm", immediate, 32'h0);
    chk("rst_mid.rd", {27'h0, rd}, 32'h0);
    chk("rst_mid.pc", pc_out, 32'h0);
    chk("rst_mid.req", {31'h0, imem_req}, 32'h1);
    chk("rst_mid.addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_mid.fetch_count", fetch_count, 32'h0);
    chk("rst_mid.stall_cycles", stall_cycles, 32'h0);
`endif
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst.req", {31'h0, imem_req}, 32'h0);
    chk("post_rst.addr", imem_addr, 32'h0);
    @(negedge clock);
    imem_valid = 1'b1; imem_rdata = 32'h00500093;
    @(posedge clock);
    #1;
    chk("post_rst.valid", {31'h0, instr_valid}, 32'h1);
    chk("post_rst.imm", immediate, 32'h5);
    chk("post_rst.pc", pc_out, 32'h0);
    chk("post_rst.next_addr", imem_addr, 32'h4);
`ifdef FETCH_PERF_EN
    chk("post_rst.fetch_count", fetch_count, 32'd1);
`endif
    @(negedge clock);
    imem_valid = 1'b0; imem_rdata = 32'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
